// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: the {pc, instr} pair that
// is buffered for decode, and the instruction size in bytes.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} pairs. Flush wins over push; a pop in the
// flush cycle is accepted, and the flush then empties the FIFO anyway.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; it is only ever read through the
    // count-qualified head mux below, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        (push && !pop && !flush) |-> (count < CW'(DEPTH)));

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        pop |-> (count != '0));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the word memory address each cycle, captures
// the registered read data and hands {pc, instr} pairs to decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int          CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);
    localparam logic [31:0] PC_MASK = ~32'(INSTR_BYTES - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  capture;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit;

    // Credits count buffered entries plus the read still in flight, so a
    // capture can never find the buffer full.
    assign pop    = valid_o && ready_i;
    assign credit = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue  = !redirect_i && !halt_i && (credit < DEPTH_C);
    assign push   = inflight && !redirect_i;

    assign capture.pc    = inflight_pc;
    assign capture.instr = mem_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC & PC_MASK;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i & PC_MASK;
            end else if (issue) begin
                fetch_pc    <= fetch_pc + 32'(INSTR_BYTES);
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (capture),
        .pop   (pop),
        .flush (redirect_i),
        .count (count),
        .head  (head)
    );

    assign mem_addr_o  = {2'b00, fetch_pc[31:2]};
    assign mem_we_o    = 1'b0;
    assign mem_wdata_o = '0;

    assign valid_o = (count != '0);
    assign instr_o = head.instr;
    assign pc_o    = head.pc;

endmodule
